// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding halfword fetch, 2-entry prefetch
// FIFO and a registered decode output with branch redirect and response draining.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [15:0] NOP      = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic [31:0] delta_instruction,
    output logic [15:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);
    typedef enum logic [1:0] {ISSUE, HOLD, DRAIN} state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [31:0] addr;
    } entry_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, stale_pc, target;
    entry_t      fifo [2];
    logic [1:0]  count, count_nxt;
    logic        accept, pop, push, bypass, wr_idx;

    assign target    = (branch_pc + 32'd4 + (delta_instruction << 1)) & ~32'd1;
    assign accept    = imem_ack && (state == ISSUE) && !branch_taken;
    assign pop       = !stall && !branch_taken && (count != 2'd0);
    assign bypass    = accept && !stall && (count == 2'd0);
    assign push      = accept && !bypass && ((count != 2'd2) || pop);
    assign wr_idx    = (count == (pop ? 2'd2 : 2'd1));
    assign count_nxt = count + {1'b0, push} - {1'b0, pop};

    // Request is masked by reset so the reset cycle never issues a fetch.
    assign imem_req  = reset && (state != HOLD);
    assign imem_addr = (state == DRAIN) ? stale_pc : fetch_pc;

    always_comb begin
        state_nxt = state;
        case (state)
            ISSUE: begin
                if (branch_taken)
                    state_nxt = imem_ack ? ISSUE : DRAIN;
                else if (count_nxt == 2'd2 && !pop)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (branch_taken || pop)
                    state_nxt = ISSUE;
            end
            DRAIN: begin
                if (imem_ack)
                    state_nxt = ISSUE;
            end
            default: state_nxt = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ISSUE;
            fetch_pc    <= RESET_PC;
            stale_pc    <= RESET_PC;
            count       <= 2'd0;
            instruction <= NOP;
            instr_pc    <= 32'd0;
            instr_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (branch_taken) begin
                fetch_pc    <= target;
                // The in-flight address must stay on the bus until its ack is drained.
                if (state == ISSUE && !imem_ack)
                    stale_pc <= fetch_pc;
                count       <= 2'd0;
                instruction <= NOP;
                instr_pc    <= 32'd0;
                instr_valid <= 1'b0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd2;
                if (pop)
                    fifo[0] <= fifo[1];
                if (push)
                    fifo[wr_idx] <= '{data: imem_rdata, addr: fetch_pc};
                count <= count_nxt;
                if (!stall) begin
                    if (count != 2'd0) begin
                        instruction <= fifo[0].data;
                        instr_pc    <= fifo[0].addr;
                        instr_valid <= 1'b1;
                    end else if (accept) begin
                        instruction <= imem_rdata;
                        instr_pc    <= fetch_pc;
                        instr_valid <= 1'b1;
                    end else begin
                        instruction <= NOP;
                        instr_pc    <= 32'd0;
                        instr_valid <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for branch/reset
// corners, and a randomized run against an in-order program-stream model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        stall = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_pc = 32'h0, delta_instruction = 32'h0;
    logic [15:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;

    logic        req2, valid2;
    logic [31:0] addr2, pc2;
    logic [15:0] instr2, rdata2;

    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [31:0] a);
        case (a)
            32'd0:   return 16'h2005;
            32'd2:   return 16'h1FC2;
            32'd4:   return 16'h628A;
            default: return a[16:1] ^ a[31:16] ^ 16'hC3A5;
        endcase
    endfunction

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_pc(branch_pc),
        .delta_instruction(delta_instruction), .instruction(instruction),
        .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    // Second instance near the top of the address space on a zero-wait memory.
    assign rdata2 = mdata(addr2);
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(req2), .imem_rdata(rdata2), .stall(1'b0),
        .branch_taken(1'b0), .branch_pc(32'h0), .delta_instruction(32'h0),
        .instruction(instr2), .instr_pc(pc2), .instr_valid(valid2)
    );

    int total = 0, bad = 0;
    int lat = 0, wcnt = 0;
    bit rnd_lat = 0;
    logic        pre_req, pre_ack;
    logic [31:0] pre_addr, pre_addr2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        if (imem_req) begin
            if (wcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mdata(imem_addr);
                wcnt       = 0;
                if (rnd_lat) lat = $urandom_range(0, 2);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'hDEAD;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b,
                        input logic [31:0] bpc, input logic [31:0] dlt);
        reset = r; stall = s; branch_taken = b;
        branch_pc = bpc; delta_instruction = dlt;
        #1;
        drive_mem();
        pre_req = imem_req; pre_addr = imem_addr; pre_ack = imem_ack; pre_addr2 = addr2;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, stl, ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [15:0] einstr;
        logic [31:0] epc;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] e2 [3];

    initial begin
        logic [31:0] exp_pc, bpc, prev_addr, prev_pc;
        logic [15:0] prev_instr;
        logic        prev_req, prev_ack, prev_vld, s, b;
        int          dlt, delivered;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 16'h0000,  32'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 16'h0000,  32'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'd0,  1'b1, 16'h2005,  32'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'd2,  1'b1, 16'h1FC2,  32'd2};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'd4,  1'b1, 16'h628A,  32'd4};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'd6,  1'b1, 16'h628A,  32'd4};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 16'h628A,  32'd4};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 16'h628A,  32'd4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, mdata(6),  32'd6};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'd10, 1'b1, mdata(8),  32'd8};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 32'd12, 1'b1, mdata(10), 32'd10};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 32'd14, 1'b1, mdata(12), 32'd12};
        e2[0] = 32'hFFFF_FFFC; e2[1] = 32'hFFFF_FFFE; e2[2] = 32'h0000_0000;

        lat = 0;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].stl, 1'b0, 32'h0, 32'h0);
            chk($sformatf("tbl%0d req", i), 32'(pre_req), 32'(tbl[i].ereq));
            if (tbl[i].ereq) chk($sformatf("tbl%0d addr", i), pre_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d vld", i), 32'(instr_valid), 32'(tbl[i].evld));
            chk($sformatf("tbl%0d instr", i), 32'(instruction), 32'(tbl[i].einstr));
            chk($sformatf("tbl%0d pc", i), instr_pc, tbl[i].epc);
            if (i >= 2 && i <= 4) begin
                chk($sformatf("wrap addr%0d", i), pre_addr2, e2[i-2]);
                chk($sformatf("wrap pc%0d", i), pc2, e2[i-2]);
                chk($sformatf("wrap instr%0d", i), 32'(instr2), 32'(mdata(e2[i-2])));
            end
        end

        // Branch while request outstanding: drain the stale response.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 2;
        step(1'b1, 1'b0, 1'b1, 32'd8, 32'hFFFF_FFFA);
        chk("br_out ack", 32'(pre_ack), 32'd0);
        chk("br_out vld", 32'(instr_valid), 32'd0);
        chk("br_out instr", 32'(instruction), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("drain req", 32'(pre_req), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("drain ack", 32'(pre_ack), 32'd1);
        chk("drain dropped", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("target addr", pre_addr, 32'd0);
        chk("post drain vld", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("target vld", 32'(instr_valid), 32'd1);
        chk("target instr", 32'(instruction), 32'h2005);
        chk("target pc", instr_pc, 32'd0);

        // Branch coincident with ack: data dropped, redirect to 10.
        lat = 0;
        step(1'b1, 1'b0, 1'b1, 32'd0, 32'd3);
        chk("br_ack ack", 32'(pre_ack), 32'd1);
        chk("br_ack vld", 32'(instr_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("br_ack addr", pre_addr, 32'd10);
        chk("br_ack pc", instr_pc, 32'd10);
        chk("br_ack instr", 32'(instruction), 32'(mdata(10)));

        // Reset during an outstanding request.
        lat = 3;
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_mid pending", 32'(pre_ack), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_mid req", 32'(pre_req), 32'd0);
        chk("rst_mid vld", 32'(instr_valid), 32'd0);
        chk("rst_mid instr", 32'(instruction), 32'h0);
        chk("rst_mid pc", instr_pc, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("restart req", 32'(pre_req), 32'd1);
        chk("restart addr", pre_addr, 32'd0);

        // Randomized run: delivered instructions must follow program order.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rnd_lat = 1; lat = 1;
        exp_pc = 32'd0; delivered = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            s   = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 15) == 0);
            bpc = 32'($urandom_range(0, 255)) << 1;
            dlt = int'($urandom_range(0, 40)) - 20;
            prev_instr = instruction; prev_pc = instr_pc; prev_vld = instr_valid;
            step(1'b1, s, b, bpc, dlt);
            if (prev_req && !prev_ack) begin
                chk("hold req", 32'(pre_req), 32'd1);
                chk("hold addr", pre_addr, prev_addr);
            end
            if (b) begin
                chk("rnd br vld", 32'(instr_valid), 32'd0);
                exp_pc = bpc + 32'd4 + 32'(dlt * 2);
            end else if (s) begin
                chk("rnd stall instr", 32'(instruction), 32'(prev_instr));
                chk("rnd stall pc", instr_pc, prev_pc);
                chk("rnd stall vld", 32'(instr_valid), 32'(prev_vld));
            end else if (instr_valid) begin
                chk("rnd pc", instr_pc, exp_pc);
                chk("rnd instr", 32'(instruction), 32'(mdata(exp_pc)));
                exp_pc = exp_pc + 32'd2;
                delivered++;
            end
            prev_req = pre_req; prev_ack = pre_ack; prev_addr = pre_addr;
        end
        chk("rnd progress", 32'(delivered >= 400), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP, default 16'h0000, meaning the bubble instruction driven to decode.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 The block SHALL have port imem_addr  output  32  byte address of the requested halfword, bit 0 always 0.
REQ-007 The block SHALL have port imem_ack  input  1  memory response valid; imem_rdata is valid in the same cycle.
REQ-008 The block SHALL have port imem_rdata  input  16  returned instruction halfword.
REQ-009 The block SHALL have port stall  input  1  decode cannot accept a new instruction this cycle.
REQ-010 The block SHALL have port branch_taken  input  1  one-cycle pulse from execute: redirect fetch.
REQ-011 The block SHALL have port branch_pc  input  32  address of the branch instruction in execute.
REQ-012 The block SHALL have port delta_instruction  input  32  signed branch offset in halfwords.
REQ-013 The block SHALL have port instruction  output  16  registered instruction to decode.
REQ-014 The block SHALL have port instr_pc  output  32  registered address of instruction.
REQ-015 The block SHALL have port instr_valid  output  1  instruction holds a real fetched instruction, not NOP.

Function
REQ-016 Memory protocol SHALL be: at most one outstanding request; imem_req and imem_addr held stable from assertion until the cycle imem_ack=1; ack allowed in the first req cycle.
REQ-017 State machine SHALL have states ISSUE (req=1, awaiting ack), HOLD (req=0, buffer full), DRAIN (req=1 at stale address, response to be discarded).
REQ-018 A 2-entry prefetch FIFO SHALL store {halfword, address} pairs; fetch_pc SHALL advance by 2 on every accepted ack, modulo 2^32 (32'hFFFF_FFFE wraps to 0).
REQ-019 ISSUE->HOLD SHALL occur on ack when the resulting occupancy is 2 with no pop this cycle; HOLD->ISSUE the cycle after occupancy drops below 2.
REQ-020 Output register update, when stall=0: load FIFO head (pop) if non-empty; else, if ack this cycle, load imem_rdata directly (bypass, 1-cycle ack-to-output latency); else load NOP, instr_valid=0.
REQ-021 When stall=1 and branch_taken=0, instruction, instr_pc, instr_valid SHALL hold; acks still fill the FIFO.
REQ-022 Simultaneous push and pop on a full FIFO SHALL be legal and keep occupancy 2; no push SHALL occur into a full FIFO without a pop.
REQ-023 On branch_taken=1: fetch_pc <= (branch_pc + 4 + (delta_instruction << 1)) with bit 0 forced to 0, 32-bit wrap; FIFO cleared; output register loaded with NOP, instr_valid=0, regardless of stall.
REQ-024 Branch with request in flight and no ack that cycle SHALL enter DRAIN; the DRAIN ack data SHALL be discarded, then ISSUE at the target.
REQ-025 Branch coincident with ack SHALL discard that data and go to ISSUE at the target next cycle.
REQ-026 Branch in HOLD or ISSUE-without-outstanding SHALL go to ISSUE at the target next cycle.
REQ-027 A second branch_taken during DRAIN SHALL overwrite the target; state remains DRAIN until ack.

Reset
REQ-028 While reset=0 at a rising edge: state=ISSUE, fetch_pc=RESET_PC, FIFO empty, instruction=NOP, instr_pc=0, instr_valid=0; imem_req SHALL be 0 during the reset cycle and 1 with imem_addr=RESET_PC the first cycle after release.
REQ-029 Reset mid-operation SHALL abandon any outstanding request without waiting for ack; an ack in the reset cycle is discarded.

Verification
REQ-030 Zero-wait memory returning 16'h2005, 16'h1FC2, 16'h628A at 0,2,4, stall=0 -> instruction sequence 2005,1FC2,628A with instr_pc 0,2,4, one per cycle, first one cycle after first ack.
REQ-031 stall=1 for 3 cycles after first instruction -> outputs frozen, imem_req low after two more acks (HOLD), release -> remaining instructions in order, none lost or duplicated.
REQ-032 branch_taken with branch_pc=8, delta_instruction=-6 while request outstanding (ack delayed 2 cycles) -> DRAIN, stale data dropped, next imem_addr=0, instr_valid=0 for the branch cycle.
REQ-033 branch_taken coincident with ack, branch_pc=0, delta=3 -> data dropped, next imem_addr=10.
REQ-034 RESET_PC=32'hFFFF_FFFC, zero-wait memory -> addresses FFFF_FFFC, FFFF_FFFE, 0000_0000.
REQ-035 reset=0 asserted during outstanding request -> next-cycle outputs NOP/0/0, imem_req=0, restart at RESET_PC after release.
